// File: rtl/cdc_src_arbiter.sv
// ---------------------------------------------------------------------------
// cdc_src_arbiter
//   Round-robin arbiter that funnels NUM_REQ requesters into the source half
//   of a two-phase CDC channel. One crossing is in flight at a time. The
//   payload and owner index are registered at grant. done_o pulses when the
//   CDC source reports the crossing complete.
//
//   Optional feature (macro CDC_ARB_TIMEOUT_EN): a watchdog bounds the time
//   spent in ISSUE+WAIT_DONE. It sets the sticky timeout_o flag and forces
//   the FSM back to IDLE. Without the macro the FSM waits indefinitely and
//   timeout_o does not exist.
//
// Ports
//   clk_i        single clock
//   rst_i        synchronous active-high reset
//   req_valid_i  [NUM_REQ]         per-requester valid
//   req_data_i   [NUM_REQ*DATA_W]  payloads, lane i at [i*DATA_W +: DATA_W]
//   req_ready_o  [NUM_REQ]         one-hot accept strobe (grant cycle only)
//   cdc_valid_o                    valid to CDC source (high only in ISSUE)
//   cdc_data_o   [DATA_W]          registered payload
//   cdc_ready_i                    CDC source idle (low = crossing in flight)
//   src_id_o     [$clog2(NUM_REQ)] owner of the channel, held until next grant
//   done_o                         one-cycle pulse on crossing completion
//   xfer_cnt_o   [16]              completed crossings, wrapping
//   timeout_o                      sticky watchdog flag (CDC_ARB_TIMEOUT_EN only)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | channel free; grants when a request is valid and CDC is ready
// ISSUE     | cdc_valid_o high, payload held until the CDC accepts it
// WAIT_DONE | crossing in flight; ends when cdc_ready_i returns high
// ---------------------------------------------------------------------------
module cdc_src_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic                        cdc_valid_o,
    output logic [DATA_W-1:0]           cdc_data_o,
    input  logic                        cdc_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]  src_id_o,
    output logic                        done_o,
    output logic [15:0]                 xfer_cnt_o
`ifdef CDC_ARB_TIMEOUT_EN
    ,
    output logic                        timeout_o
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 1) begin : g_param_check
        $error("cdc_src_arbiter: NUM_REQ must be 2..16 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ID_W-1:0]     src_id_q, src_id_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic                wait_first_q, wait_first_d;
    logic                done_q, done_d;
    logic [15:0]         xfer_cnt_q, xfer_cnt_d;

    logic                win_found;
    logic [ID_W-1:0]     win_idx;
    logic [DATA_W-1:0]   win_data;
    logic                grant;

`ifdef CDC_ARB_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                timeout_q, timeout_d;
`endif

    // Rotating priority: indices above last_q are scanned before the wrapped
    // segment. Each loop runs from the top down so the lowest matching index
    // is the last one written. The second loop overrides the first.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i] && (ID_W'(i) <= last_q)) begin
                win_found = 1'b1;
                win_idx   = ID_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i] && (ID_W'(i) > last_q)) begin
                win_found = 1'b1;
                win_idx   = ID_W'(i);
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == win_idx) begin
                win_data = req_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // done_q blocks a grant so crossings are separated by at least one IDLE cycle.
    assign grant = (state_q == IDLE) && cdc_ready_i && win_found && !done_q && !rst_i;

    always_comb begin
        req_ready_o = '0;
        if (grant) begin
            req_ready_o[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        src_id_d     = src_id_q;
        last_d       = last_q;
        wait_first_d = 1'b0;
        done_d       = 1'b0;
        xfer_cnt_d   = xfer_cnt_q;
`ifdef CDC_ARB_TIMEOUT_EN
        wd_d         = wd_q;
        timeout_d    = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d  = ISSUE;
                    data_d   = win_data;
                    src_id_d = win_idx;
                    last_d   = win_idx;
                end
            end
            ISSUE: begin
                if (cdc_ready_i) begin
                    state_d      = WAIT_DONE;
                    wait_first_d = 1'b1;
                end
            end
            WAIT_DONE: begin
                // cdc_ready_i may still read high in the first cycle after
                // the handshake, before the CDC source has dropped it.
                if (!wait_first_q && cdc_ready_i) begin
                    state_d    = IDLE;
                    done_d     = 1'b1;
                    xfer_cnt_d = xfer_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef CDC_ARB_TIMEOUT_EN
        if (state_q != IDLE) begin
            wd_d = wd_q + 1'b1;
            if (wd_q == WD_W'(TIMEOUT - 1)) begin
                state_d      = IDLE;
                wait_first_d = 1'b0;
                done_d       = 1'b0;
                xfer_cnt_d   = xfer_cnt_q;
                timeout_d    = 1'b1;
            end
        end
        if (grant) begin
            wd_d = '0;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            data_q       <= '0;
            src_id_q     <= '0;
            last_q       <= ID_W'(NUM_REQ - 1);
            wait_first_q <= 1'b0;
            done_q       <= 1'b0;
            xfer_cnt_q   <= '0;
`ifdef CDC_ARB_TIMEOUT_EN
            wd_q         <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            src_id_q     <= src_id_d;
            last_q       <= last_d;
            wait_first_q <= wait_first_d;
            done_q       <= done_d;
            xfer_cnt_q   <= xfer_cnt_d;
`ifdef CDC_ARB_TIMEOUT_EN
            wd_q         <= wd_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign cdc_valid_o = (state_q == ISSUE);
    assign cdc_data_o  = data_q;
    assign src_id_o    = src_id_q;
    assign done_o      = done_q;
    assign xfer_cnt_o  = xfer_cnt_q;
`ifdef CDC_ARB_TIMEOUT_EN
    assign timeout_o   = timeout_q;
`endif

endmodule

// File: tb/tb_cdc_src_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdc_src_arbiter
//   Randomized bench for cdc_src_arbiter (NUM_REQ=4, DATA_W=32). The
//   reference model keeps only the last granted index and the completion
//   count. It derives each expected winner by scanning the request mask from
//   last+1 with wrap. Inputs are driven on the falling edge. Outputs are
//   sampled on the falling edge or 1 ns after it.
// ---------------------------------------------------------------------------
module tb_cdc_src_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         cdc_valid;
    logic [31:0]  cdc_data;
    logic         cdc_ready;
    logic [1:0]   src_id;
    logic         done;
    logic [15:0]  xfer_cnt;
`ifdef CDC_ARB_TIMEOUT_EN
    logic         timeout;
`endif

    always #5 clk = ~clk;

    cdc_src_arbiter #(
        .NUM_REQ (4),
        .DATA_W  (32),
`ifdef CDC_ARB_TIMEOUT_EN
        .TIMEOUT (16)
`else
        .TIMEOUT (255)
`endif
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .cdc_valid_o (cdc_valid),
        .cdc_data_o  (cdc_data),
        .cdc_ready_i (cdc_ready),
        .src_id_o    (src_id),
        .done_o      (done),
        .xfer_cnt_o  (xfer_cnt)
`ifdef CDC_ARB_TIMEOUT_EN
        ,
        .timeout_o   (timeout)
`endif
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          last_m = 3;
    int          cnt_m = 0;
    bit          fixed_data = 1'b0;
    logic [31:0] lane [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_winner(input logic [3:0] m);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last_m + k) % 4;
            if (m[c]) return c;
        end
        return 0;
    endfunction

    task automatic set_lanes();
        for (int i = 0; i < 4; i++) begin
            lane[i] = fixed_data ? (32'hCAFE_0000 | 32'(i)) : $urandom;
            req_data[i*32 +: 32] = lane[i];
        end
    endtask

    // One complete crossing. stall = cycles cdc_ready is held low during
    // ISSUE, rt = extra cycles of CDC round trip, abort = reset in WAIT_DONE.
    task automatic crossing(input logic [3:0] mask, input int stall, input int rt, input bit abort);
        int          w;
        int          n;
        logic [31:0] exp_d;
        req_valid = mask;
        set_lanes();
        #1;
        w = model_winner(mask);
        n = 0;
        while (req_ready == 4'b0 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("grant_onehot", {28'b0, req_ready}, 32'(4'b0001 << w));
        exp_d  = lane[w];
        last_m = w;
        @(negedge clk);
        if (!fixed_data) set_lanes();
        chk("issue_valid", {31'b0, cdc_valid}, 1);
        chk("issue_src_id", {30'b0, src_id}, 32'(w));
        chk("issue_data", cdc_data, exp_d);
        chk("issue_no_ready", {28'b0, req_ready}, 0);
        if (stall > 0) begin
            cdc_ready = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                chk("hold_valid", {31'b0, cdc_valid}, 1);
                chk("hold_data", cdc_data, exp_d);
            end
            cdc_ready = 1'b1;
        end
        @(negedge clk);
        cdc_ready = 1'b0;
        chk("wait_valid_low", {31'b0, cdc_valid}, 0);
        if (abort) begin
            rst       = 1'b1;
            cdc_ready = 1'b1;
            @(negedge clk);
            #1;
            chk("abort_no_done", {31'b0, done}, 0);
            chk("abort_cnt", {16'b0, xfer_cnt}, 0);
            chk("abort_no_ready", {28'b0, req_ready}, 0);
            chk("abort_valid", {31'b0, cdc_valid}, 0);
            rst    = 1'b0;
            last_m = 3;
            cnt_m  = 0;
            return;
        end
        if (rt > 0) begin
            repeat (rt) @(negedge clk);
        end
        cdc_ready = 1'b1;
        n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", {31'b0, done}, 1);
        chk("done_latency", n, (rt == 0) ? 2 : 1);
        cnt_m = (cnt_m + 1) % 65536;
        chk("xfer_cnt", {16'b0, xfer_cnt}, cnt_m);
        chk("no_grant_on_done", {28'b0, req_ready}, 0);
        @(negedge clk);
        chk("done_pulse_width", {31'b0, done}, 0);
        chk("src_id_held", {30'b0, src_id}, 32'(w));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 4'hF;
        cdc_ready = 1'b1;
        set_lanes();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", {28'b0, req_ready}, 0);
        chk("rst_valid", {31'b0, cdc_valid}, 0);
        chk("rst_data", cdc_data, 0);
        chk("rst_src_id", {30'b0, src_id}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_cnt", {16'b0, xfer_cnt}, 0);
`ifdef CDC_ARB_TIMEOUT_EN
        chk("rst_timeout", {31'b0, timeout}, 0);
`endif
        rst = 1'b0;

        // All four requesting: order 0,1,2,3,0.
        for (int i = 0; i < 5; i++) crossing(4'hF, 0, 3, 1'b0);
        chk("five_done_cnt", {16'b0, xfer_cnt}, 5);

        // Single requester wins every time with the fixed lane payloads.
        fixed_data = 1'b1;
        for (int i = 0; i < 4; i++) begin
            crossing(4'b0100, 0, 3, 1'b0);
            chk("lane2_payload", cdc_data, 32'hCAFE_0002);
        end
        fixed_data = 1'b0;

        // CDC busy while idle: no grant until cdc_ready returns.
        cdc_ready = 1'b0;
        req_valid = 4'b0011;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("busy_no_ready", {28'b0, req_ready}, 0);
            chk("busy_no_valid", {31'b0, cdc_valid}, 0);
        end
        cdc_ready = 1'b1;
        #1;
        chk("busy_first_grant", {28'b0, req_ready}, 32'(4'b0001 << model_winner(4'b0011)));
        crossing(4'b0011, 0, 3, 1'b0);

        // Three completions, then reset during WAIT_DONE.
        for (int i = 0; i < 3; i++) crossing(4'($urandom_range(1, 15)), 0, 3, 1'b0);
        crossing(4'hF, 0, 3, 1'b1);
        crossing(4'hF, 0, 3, 1'b0);

        // Random masks, ISSUE stalls and round-trip lengths.
        for (int i = 0; i < 40; i++) begin
            crossing(4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 4), 1'b0);
        end

        // Counter wrap: preload close to 0xFFFF while idle, then run past it.
        req_valid = 4'b0;
        @(negedge clk);
        force dut.xfer_cnt_q = 16'hFFFD;
        @(negedge clk);
        release dut.xfer_cnt_q;
        @(negedge clk);
        cnt_m = 16'hFFFD;
        chk("preload_cnt", {16'b0, xfer_cnt}, cnt_m);
        for (int i = 0; i < 4; i++) crossing(4'($urandom_range(1, 15)), 0, 2, 1'b0);
        chk("wrapped_cnt", {16'b0, xfer_cnt}, 1);

`ifdef CDC_ARB_TIMEOUT_EN
        // CDC never completes: watchdog fires 16 cycles after ISSUE entry.
        begin
            int w;
            int cnt_before;
            cnt_before = cnt_m;
            req_valid  = 4'b0001;
            #1;
            w = model_winner(4'b0001);
            chk("to_grant", {28'b0, req_ready}, 32'(4'b0001 << w));
            last_m = w;
            @(negedge clk);
            chk("to_issue", {31'b0, cdc_valid}, 1);
            @(negedge clk);
            cdc_ready = 1'b0;
            for (int i = 0; i < 14; i++) begin
                chk("to_not_yet", {31'b0, timeout}, 0);
                @(negedge clk);
            end
            chk("to_not_yet_last", {31'b0, timeout}, 0);
            @(negedge clk);
            chk("to_set", {31'b0, timeout}, 1);
            chk("to_valid_low", {31'b0, cdc_valid}, 0);
            chk("to_no_done", {31'b0, done}, 0);
            chk("to_cnt_kept", {16'b0, xfer_cnt}, cnt_before);
            cdc_ready = 1'b1;
            #1;
            chk("to_idle_grant", {28'b0, req_ready}, 32'(4'b0001 << model_winner(4'b0001)));
            repeat (30) @(negedge clk);
            chk("to_sticky", {31'b0, timeout}, 1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
